sd_cmd_responder: RTL

//  Card-side end of the SD CMD line. Deserialises host commands (48-bit), checks framing
//  and CRC7, hands index/argument to a local card model, then serialises the supplied
//  R1/R2/R3 response back onto CMD. Used as the loopback/emulation partner of the
//  uSD host command path in the COB DPM uSD bench and emulation builds.

---
 rtl/sd_cmd_pkg.sv | 37 +++
 rtl/sd_crc7.sv | 29 ++
 rtl/sd_cmd_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the card-side SD CMD line responder.
// Holds response type codes, FSM state encoding, frame lengths and the
// CRC7 (x^7 + x^3 + 1) single-bit update step used by sd_crc7.
package sd_cmd_pkg;

  // Response type codes as presented on rspType
  localparam logic [1:0] RSP_NONE  = 2'd0;  // no response
  localparam logic [1:0] RSP_SHORT = 2'd1;  // 48-bit with CRC (R1/R6/R7)
  localparam logic [1:0] RSP_LONG  = 2'd2;  // 136-bit R2 (CID/CSD)
  localparam logic [1:0] RSP_OCR   = 2'd3;  // 48-bit R3, CRC field all ones

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RX       = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_WAIT_RSP = 3'd3;
  localparam logic [2:0] ST_TX       = 3'd4;

  // Shift register spans the longest frame
  localparam int SR_W = 136;

  // Frame geometry, expressed as bit positions counted from the start bit
  localparam logic [7:0] CMD_LEN        = 8'd48;
  localparam logic [7:0] LONG_LEN       = 8'd136;
  localparam logic [7:0] SHORT_CRC_POS  = 8'd40;
  localparam logic [7:0] LONG_CRC_POS   = 8'd128;
  localparam logic [7:0] LONG_CRC_FIRST = 8'd8;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker, one bit per clock, MSB of the message first.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : zero the remainder (has priority over en)
//   en         : fold din into the remainder this cycle
//   din        : message bit
//   crc        : current remainder
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_next(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side end of the SD CMD line: receives 48-bit host commands, checks
// framing and CRC7, hands index/argument to a local card model, then
// serialises the R1/R2/R3 response it supplies back onto CMD.
// Ports:
//   sdClk, sysRstN          : card clock (rising edge), async active-low reset
//   sdCmdIn                 : CMD line sampled from the pad
//   sdCmdOut, sdCmdEn       : registered CMD drive value and output enable
//   cmdValid, cmdCrcErr     : 1-cycle pulses for a good / dropped command
//   cmdIndex, cmdArg        : last good command, held until the next one
//   rspReady, rspValid      : response handshake with the card model
//   rspType, rspIndex,
//   rspPayload              : response description (see sd_cmd_pkg codes)
//   rspTimeout              : 1-cycle pulse when no response arrived by NCR_MAX
//   busy                    : high in any state other than IDLE
module sd_cmd_responder
  import sd_cmd_pkg::*;
#(
  parameter int NCR_CYCLES = 2,
  parameter int NCR_MAX    = 64
) (
  input  logic         sdClk,
  input  logic         sysRstN,
  input  logic         sdCmdIn,
  output logic         sdCmdOut,
  output logic         sdCmdEn,
  output logic         cmdValid,
  output logic [5:0]   cmdIndex,
  output logic [31:0]  cmdArg,
  output logic         cmdCrcErr,
  output logic         rspReady,
  input  logic         rspValid,
  input  logic [1:0]   rspType,
  input  logic [5:0]   rspIndex,
  input  logic [119:0] rspPayload,
  output logic         rspTimeout,
  output logic         busy
);

  localparam logic [7:0] NCR_C = 8'(NCR_CYCLES);
  localparam logic [7:0] NCR_M = 8'(NCR_MAX);

  logic [2:0]      state;
  logic [7:0]      cnt;       // bits seen in RX, n in CHECK/WAIT_RSP, bits sent in TX
  logic [SR_W-1:0] sr;
  logic [1:0]      tx_type;
  logic            rsp_held;  // response captured before NCR_CYCLES elapsed

  logic [6:0] rx_crc, tx_crc;
  logic       rx_crc_clr, rx_crc_en;
  logic       tx_crc_clr, tx_crc_en;

  logic [7:0]      tx_len, crc_pos, crc_first;
  logic [2:0]      crc_sel;
  logic            in_crc, tx_bit, rx_good, rsp_fire;
  logic [SR_W-1:0] rsp_frame;

  always_comb begin
    busy     = (state != ST_IDLE);
    rspReady = (state == ST_WAIT_RSP) && !rsp_held;
    rsp_fire = rspValid && rspReady;
    rx_good  = (rx_crc == sr[7:1]) && sr[0];

    tx_len    = (tx_type == RSP_LONG) ? LONG_LEN : CMD_LEN;
    crc_pos   = (tx_type == RSP_LONG) ? LONG_CRC_POS : SHORT_CRC_POS;
    crc_first = (tx_type == RSP_LONG) ? LONG_CRC_FIRST : 8'd0;
    // Inside the CRC field the remainder is sent MSB first instead of sr
    in_crc    = (tx_type != RSP_OCR) && (cnt >= crc_pos) && (cnt < crc_pos + 8'd7);
    crc_sel   = 3'd6 - 3'(cnt - crc_pos);
    tx_bit    = in_crc ? tx_crc[crc_sel] : sr[SR_W-1];

    // Start bit is zero, so leaving it out of either CRC changes nothing
    rx_crc_clr = (state == ST_IDLE);
    rx_crc_en  = (state == ST_RX) && (cnt < SHORT_CRC_POS);
    tx_crc_clr = (state != ST_TX);
    tx_crc_en  = (state == ST_TX) && (cnt >= crc_first) && (cnt < crc_pos);

    // Frame loaded with bit 1 at the MSB; the start bit goes straight to sdCmdOut
    case (rspType)
      RSP_LONG: rsp_frame = {1'b0, 6'h3F, rspPayload, 7'h00, 1'b1, 1'b0};
      RSP_OCR:  rsp_frame = {1'b0, 6'h3F, rspPayload[31:0], 7'h7F, 1'b1, 89'd0};
      default:  rsp_frame = {1'b0, rspIndex, rspPayload[31:0], 7'h00, 1'b1, 89'd0};
    endcase
  end

  sd_crc7 u_rx_crc (
    .clk   (sdClk),
    .rst_n (sysRstN),
    .clear (rx_crc_clr),
    .en    (rx_crc_en),
    .din   (sdCmdIn),
    .crc   (rx_crc)
  );

  sd_crc7 u_tx_crc (
    .clk   (sdClk),
    .rst_n (sysRstN),
    .clear (tx_crc_clr),
    .en    (tx_crc_en),
    .din   (tx_bit),
    .crc   (tx_crc)
  );

  // Shared data shift register: receive in IDLE/RX, load on handshake, shift out in TX
  always_ff @(posedge sdClk) begin
    case (state)
      ST_IDLE, ST_RX: sr <= {sr[SR_W-2:0], sdCmdIn};
      ST_WAIT_RSP:    if (rsp_fire) sr <= rsp_frame;
      ST_TX:          sr <= {sr[SR_W-2:0], 1'b0};
      default:        ;
    endcase
  end

  always_ff @(posedge sdClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      tx_type    <= RSP_NONE;
      rsp_held   <= 1'b0;
      sdCmdOut   <= 1'b1;
      sdCmdEn    <= 1'b0;
      cmdValid   <= 1'b0;
      cmdCrcErr  <= 1'b0;
      rspTimeout <= 1'b0;
      cmdIndex   <= 6'd0;
      cmdArg     <= 32'd0;
    end else begin
      cmdValid   <= 1'b0;
      cmdCrcErr  <= 1'b0;
      rspTimeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!sdCmdIn) begin
            state <= ST_RX;
            cnt   <= 8'd1;
          end
        end
        ST_RX: begin
          if (cnt == 8'd1 && !sdCmdIn) begin
            state <= ST_IDLE;            // transmission bit must be 1
          end else if (cnt == CMD_LEN - 8'd1) begin
            state <= ST_CHECK;           // end bit just sampled
            cnt   <= 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_CHECK: begin
          if (rx_good) begin
            cmdValid <= 1'b1;
            cmdIndex <= sr[45:40];
            cmdArg   <= sr[39:8];
            rsp_held <= 1'b0;
            state    <= ST_WAIT_RSP;
            cnt      <= 8'd2;
          end else begin
            cmdCrcErr <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_fire && rspType == RSP_NONE) begin
            state <= ST_IDLE;
          end else if (rsp_fire || rsp_held) begin
            if (rsp_fire) begin
              tx_type  <= rspType;
              rsp_held <= 1'b1;
            end
            if (cnt >= NCR_C) begin
              state    <= ST_TX;
              cnt      <= 8'd1;
              sdCmdOut <= 1'b0;
              sdCmdEn  <= 1'b1;
              rsp_held <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else if (cnt >= NCR_M) begin
            rspTimeout <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_TX: begin
          if (cnt == tx_len) begin
            sdCmdOut <= 1'b1;
            sdCmdEn  <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            sdCmdOut <= tx_bit;
            cnt      <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
